updown_step_sched: RTL

Step scheduler and round-robin arbiter for the 4-bit up/down counter datapath. It shares the counter between two requesters, an "up" source and a "down" source such as debounced push-buttons. It paces repeated steps while a request is held and gives clear requests priority. It drives the counter's step strobe, direction and clear, keeps a shadow count for bound handling, and drives the 7-segment direction glyph.

---
 rtl/updown_step_sched_pkg.sv | 21 ++
 rtl/updown_step_sched_if.sv | 32 +++
 rtl/updown_step_sched_rr_arb2.sv | 33 +++
 rtl/updown_step_sched.sv | 131 +++++++++++++
 4 files changed

// File: rtl/updown_step_sched_pkg.sv
// Shared types and constants for the up/down step scheduler.
// Latency: none (declarations only).
// Backpressure: none.
// Contents: FSM state enum, direction constants, 7-segment glyphs.
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam logic [6:0] SEG_UP  = 7'b0111110;
  localparam logic [6:0] SEG_DN  = 7'b1011110;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/updown_step_sched_if.sv
// Request/grant bundle between the up/down requesters and the step scheduler.
// Latency: none (wires only).
// Backpressure: none; requests are levels, strobes are single-cycle.
// Ports: req_up/req_dn/req_clr (requester -> scheduler), gnt_up/gnt_dn/step/
//        dir/cnt_clr/count/seg/busy (scheduler -> counter, display, requesters).
interface updown_step_sched_if #(
  parameter int WIDTH = 4
);
  logic             req_up;
  logic             req_dn;
  logic             req_clr;
  logic             gnt_up;
  logic             gnt_dn;
  logic             step;
  logic             dir;
  logic             cnt_clr;
  logic [WIDTH-1:0] count;
  logic [6:0]       seg;
  logic             busy;

  // Requester side.
  modport master (
    output req_up, req_dn, req_clr,
    input  gnt_up, gnt_dn, step, dir, cnt_clr, count, seg, busy
  );

  // Scheduler side.
  modport slave (
    input  req_up, req_dn, req_clr,
    output gnt_up, gnt_dn, step, dir, cnt_clr, count, seg, busy
  );
endinterface

// File: rtl/updown_step_sched_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the enabled edge.
// Backpressure: none; the caller decides when a grant is taken via en.
// Ports: clk, clr_n (sync active-low), en, req[0]=up/req[1]=dn, gnt one-hot.
module rr_arb2 (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = requester 1 (dn) was granted last, so requester 0 (up) wins a tie.
  logic last_dn_q;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_dn_q)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      last_dn_q <= 1'b1;
    end else if (en && (gnt != 2'b00)) begin
      last_dn_q <= gnt[1];
    end
  end

endmodule

// File: rtl/updown_step_sched.sv
// Step scheduler + round-robin arbiter sharing a WIDTH-bit up/down counter.
// Latency: request seen at an IDLE edge -> grant/step/new count after that edge;
//          held requests repeat every PACE cycles.
// Backpressure: none; requests are levels, clear pre-empts any step in progress.
// Ports: clk, clr_n (sync active-low), bus (slave side of updown_step_sched_if).
// Config: define UPDOWN_SAT_EN to saturate count at 0 / 2^WIDTH-1 instead of wrapping.
module updown_step_sched
  import updown_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PACE  = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  updown_step_sched_if.slave  bus
);

  localparam int WW = (PACE > 2) ? $clog2(PACE) : 1;

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q;
  logic             gnt_up_q, gnt_dn_q;
  logic             step_ok_q;
  logic [WIDTH-1:0] count_q;
  logic [6:0]       seg_q;

  logic             any_req;
  logic             arb_pt;
  logic             arb_fire;
  logic [1:0]       win;
  logic             step_ok_d;
  logic [WIDTH-1:0] count_nxt;

  assign any_req  = bus.req_up | bus.req_dn;
  // Arbitration happens in IDLE and on the last WAIT cycle; clear overrides it.
  assign arb_pt   = (state_q == IDLE) | ((state_q == WAIT) & (wait_q == '0));
  assign arb_fire = arb_pt & any_req & ~bus.req_clr;

  rr_arb2 u_arb (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (arb_fire),
    .req   ({bus.req_dn, bus.req_up}),
    .gnt   (win)
  );

  assign count_nxt = win[0] ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));

`ifdef UPDOWN_SAT_EN
  // Suppress the step at the bounds; grant and pacing still proceed.
  assign step_ok_d = win[0] ? (count_q != '1) : (count_q != '0);
`else
  assign step_ok_d = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.req_clr) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        IDLE:    if (any_req) state_d = STEP;
        STEP:    state_d = WAIT;
        WAIT:    if (wait_q == '0) state_d = any_req ? STEP : IDLE;
        CLEAR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered datapath: grants, glyph and shadow count change at the
  // arbitration edge so they are valid for the whole STEP cycle.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wait_q    <= '0;
      gnt_up_q  <= 1'b0;
      gnt_dn_q  <= 1'b0;
      step_ok_q <= 1'b0;
      count_q   <= '0;
      seg_q     <= SEG_OFF;
    end else begin
      if (state_q == STEP) begin
        wait_q <= WW'(PACE - 2);
      end else if ((state_q == WAIT) && (wait_q != '0)) begin
        wait_q <= wait_q - WW'(1);
      end

      if (bus.req_clr) begin
        gnt_up_q  <= 1'b0;
        gnt_dn_q  <= 1'b0;
        step_ok_q <= 1'b0;
        count_q   <= '0;
        seg_q     <= SEG_OFF;
      end else if (arb_fire) begin
        gnt_up_q  <= win[0];
        gnt_dn_q  <= win[1];
        step_ok_q <= step_ok_d;
        seg_q     <= win[0] ? SEG_UP : SEG_DN;
        if (step_ok_d) begin
          count_q <= count_nxt;
        end
      end else if (arb_pt) begin
        gnt_up_q <= 1'b0;
        gnt_dn_q <= 1'b0;
      end
    end
  end

  // Output logic.
  always_comb begin
    bus.step    = (state_q == STEP) & step_ok_q;
    bus.cnt_clr = (state_q == CLEAR);
    bus.busy    = (state_q != IDLE);
    bus.gnt_up  = gnt_up_q;
    bus.gnt_dn  = gnt_dn_q;
    bus.dir     = gnt_up_q ? DIR_UP : DIR_DN;
    bus.count   = count_q;
    bus.seg     = seg_q;
  end

endmodule
